// File: rtl/majority_logic_primitive.sv
// Bitwise 4-input threshold voter with a combinational result and a registered
// copy (result, 2-of-4 tie flag, valid strobe) for synchronous consumers.
module majority_logic_primitive #(
  parameter int WIDTH     = 1,
  parameter int THRESHOLD = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] tie_q,
  output logic             out_valid
);

  if (THRESHOLD < 1 || THRESHOLD > 4) begin : g_bad_threshold
    $error("majority_logic_primitive: THRESHOLD must be in 1..4");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("majority_logic_primitive: WIDTH must be at least 1");
  end

  // OR of ANDs over every input subset of size >= THRESHOLD. Being monotone,
  // unknown inputs only yield x when the known ones cannot decide the vote.
  function automatic logic vote(input logic [3:0] v);
    logic       acc;
    logic       term;
    logic [3:0] sel;
    acc = 1'b0;
    for (int m = 1; m < 16; m++) begin
      sel = 4'(m);
      if ($countones(sel) >= THRESHOLD) begin
        term = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (sel[k]) term = term & v[k];
        end
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [WIDTH-1:0] tie;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    always_comb begin
      y[i]   = vote({d[i], c[i], b[i], a[i]});
      tie[i] = (count_ones({d[i], c[i], b[i], a[i]}) == 3'd2);
    end
  end

  // Results only advance on qualified samples; the strobe tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      tie_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q   <= y;
        tie_q <= tie;
      end
    end
  end

endmodule

// File: tb/tb_majority_logic_primitive.sv
// Scoreboard bench for majority_logic_primitive: a 4-lane THRESHOLD=3 voter and
// a 1-lane THRESHOLD=2 voter sharing lane 0 of the same stimulus.
module tb_majority_logic_primitive;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, c, d;
  logic       in_valid;
  logic [3:0] y, y_q, tie_q;
  logic       out_valid;
  logic       y2, y_q2, tie_q2, out_valid2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] y;
    logic [3:0] tie;
    logic       y2;
    logic       tie2;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  exp_t cur;
  logic exp_valid;
  logic monitor_on;

  majority_logic_primitive #(.WIDTH(4), .THRESHOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .y(y), .y_q(y_q), .tie_q(tie_q), .out_valid(out_valid)
  );

  majority_logic_primitive #(.WIDTH(1), .THRESHOLD(2)) dut_t2 (
    .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
    .in_valid(in_valid), .y(y2), .y_q(y_q2), .tie_q(tie_q2), .out_valid(out_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: count the ones per lane and compare against the threshold.
  function automatic exp_t model(input logic [3:0] va, vb, vc, vd);
    exp_t e;
    int   n;
    for (int i = 0; i < 4; i++) begin
      n = int'(va[i]) + int'(vb[i]) + int'(vc[i]) + int'(vd[i]);
      e.y[i]   = (n >= 3);
      e.tie[i] = (n == 2);
      if (i == 0) begin
        e.y2   = (n >= 2);
        e.tie2 = (n == 2);
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [3:0] va, vb, vc, vd, input logic v);
    @(negedge clk);
    #1;
    a = va; b = vb; c = vc; d = vd; in_valid = v;
    cur = model(va, vb, vc, vd);
    if (v) sb.push_back(cur);
    #1;
    checkOutput("comb_y", 32'(y), 32'(cur.y));
    checkOutput("comb_y_t2", 32'(y2), 32'(cur.y2));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_valid = 1'b0;
    else        exp_valid = in_valid;
  end

  // Pops one expectation per out_valid strobe; otherwise the registers must hold.
  always @(negedge clk) begin
    if (monitor_on) begin
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("out_valid_t2", 32'(out_valid2), 32'(exp_valid));
      if (out_valid) begin
        checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          held = sb.pop_front();
          checkOutput("y_q", 32'(y_q), 32'(held.y));
          checkOutput("tie_q", 32'(tie_q), 32'(held.tie));
          checkOutput("y_q_t2", 32'(y_q2), 32'(held.y2));
          checkOutput("tie_q_t2", 32'(tie_q2), 32'(held.tie2));
        end
      end else begin
        checkOutput("hold_y_q", 32'(y_q), 32'(held.y));
        checkOutput("hold_tie_q", 32'(tie_q), 32'(held.tie));
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  v;
    monitor_on = 1'b0;
    held       = '{default: '0};
    rst_n      = 1'b0;
    a = '0; b = '0; c = '0; d = '0; in_valid = 1'b0;
    #12;
    checkOutput("reset_y_q", 32'(y_q), 32'h0);
    checkOutput("reset_tie_q", 32'(tie_q), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_y", 32'(y), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    monitor_on = 1'b1;

    // Exhaustive lane-0 sweep, abcd = v[3:0]; upper lanes carry random votes.
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      r = $urandom;
      applyStimulus({r[2:0], v[3]}, {r[5:3], v[2]}, {r[8:6], v[1]}, {r[11:9], v[0]}, 1'b1);
      checkOutput("sweep_lane0", 32'(y[0]), 32'(v == 4'b0111 || v == 4'b1011 ||
                  v == 4'b1101 || v == 4'b1110 || v == 4'b1111));
    end

    // Tie then 3-of-4 on lane 0.
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1);
    @(posedge clk); #1;
    checkOutput("tie_0011_y_q", 32'(y_q[0]), 32'h0);
    checkOutput("tie_0011_tie_q", 32'(tie_q[0]), 32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    @(posedge clk); #1;
    checkOutput("maj_1101_y_q", 32'(y_q[0]), 32'h1);
    checkOutput("maj_1101_tie_q", 32'(tie_q[0]), 32'h0);

    // Hold with in_valid low.
    applyStimulus(4'hF, 4'hF, 4'h0, 4'hF, 1'b1);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("hold_comb_y", 32'(y), 32'h0);
    @(posedge clk); #1;
    checkOutput("hold_y_q_after_edge", 32'(y_q), 32'hF);
    checkOutput("hold_out_valid_after_edge", 32'(out_valid), 32'h0);

    // Lane-wise mix.
    applyStimulus(4'b1111, 4'b1100, 4'b1010, 4'b0000, 1'b1);
    checkOutput("lanes_y", 32'(y), 32'b1000);
    @(posedge clk); #1;
    checkOutput("lanes_tie_q", 32'(tie_q), 32'b0110);

    // THRESHOLD=2 instance on lane 0.
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    checkOutput("t2_0101_y", 32'(y2), 32'h1);
    @(posedge clk); #1;
    checkOutput("t2_0101_tie_q", 32'(tie_q2), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    checkOutput("t2_0001_y", 32'(y2), 32'h0);

    // Asynchronous reset between edges with y_q and tie_q both set.
    applyStimulus(4'b0001, 4'b0001, 4'b0011, 4'b0011, 1'b1);
    @(posedge clk); #1;
    checkOutput("pre_reset_y_q", 32'(y_q[0]), 32'h1);
    checkOutput("pre_reset_tie_q", 32'(tie_q[1]), 32'h1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    held = '{default: '0};
    #1;
    checkOutput("async_reset_y_q", 32'(y_q), 32'h0);
    checkOutput("async_reset_tie_q", 32'(tie_q), 32'h0);
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("async_reset_y", 32'(y), 32'(model(a, b, c, d).y));
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Unknown inputs: decided when the known votes settle it, x otherwise.
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    a = 4'b0001; b = 4'b0001; c = 4'b0001; d = 4'b000x; #1;
    checkOutput("x_decided_one", 32'(y[0]), 32'h1);
    a = 4'b0000; b = 4'b0000; c = 4'b000x; d = 4'b0001; #1;
    checkOutput("x_decided_zero", 32'(y[0]), 32'h0);
    a = 4'b0001; b = 4'b0001; c = 4'b0000; d = 4'b000x; #1;
    checkOutput("x_undecided", 32'(y[0]), {31'b0, 1'bx});
    a = 4'b0000; d = 4'b0000; #1;

    // Random traffic with sporadic in_valid gaps.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      applyStimulus(r[3:0], r[7:4], r[11:8], r[15:12], r[16] | r[17]);
    end
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);
    monitor_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
